fp_add_sub: RTL and testbench

Multi-cycle IEEE-754 floating-point adder/subtractor, parameterised for single or double precision. It is the shared add unit that the divider's Newton-Raphson sequencer drives through its `toAdd*` / `fromAdd*` ports, and it also serves top-level add/subtract operations. It accepts one operation per `Load` pulse and holds the rounded result with `Valid` high until the next `Load`.

---
 rtl/fp_pkg.sv | 37 +++
 rtl/fp_add_sub_if.sv | 16 +
 rtl/fp_lzc.sv | 16 +
 rtl/fp_add_sub.sv | 166 ++++++++++++++++
 tb/tb_fp_add_sub.sv | 186 ++++++++++++++++++
 5 files changed

// File: rtl/fp_pkg.sv
// Shared floating-point definitions for the add, multiply and divide units:
// field positions per precision, common constants and the sequencer state type.
package fp_pkg;

    localparam int SP_E = 30;
    localparam int SP_M = 22;
    localparam int DP_E = 62;
    localparam int DP_M = 51;

    localparam logic [31:0] SP_ZERO = 32'h0000_0000;
    localparam logic [31:0] SP_HALF = 32'h3F00_0000;
    localparam logic [31:0] SP_ONE  = 32'h3F80_0000;
    localparam logic [31:0] SP_TWO  = 32'h4000_0000;
    localparam logic [31:0] SP_PINF = 32'h7F80_0000;
    localparam logic [31:0] SP_NINF = 32'hFF80_0000;
    localparam logic [31:0] SP_NAN  = 32'h7FFF_FFFF;

    localparam logic [63:0] DP_ZERO = 64'h0000_0000_0000_0000;
    localparam logic [63:0] DP_HALF = 64'h3FE0_0000_0000_0000;
    localparam logic [63:0] DP_ONE  = 64'h3FF0_0000_0000_0000;
    localparam logic [63:0] DP_TWO  = 64'h4000_0000_0000_0000;
    localparam logic [63:0] DP_PINF = 64'h7FF0_0000_0000_0000;
    localparam logic [63:0] DP_NINF = 64'hFFF0_0000_0000_0000;
    localparam logic [63:0] DP_NAN  = 64'h7FFF_FFFF_FFFF_FFFF;

    typedef enum logic [2:0] {IDLE, ALIGN, ADD, NORM, ROUND, DONE} fp_state_e;

    // MSB index of the exponent / mantissa fields for a given operand width.
    function automatic int exp_msb(input int precision);
        return (precision == 64) ? DP_E : SP_E;
    endfunction

    function automatic int man_msb(input int precision);
        return (precision == 64) ? DP_M : SP_M;
    endfunction

endpackage

// File: rtl/fp_add_sub_if.sv
// Operand/result bundle between an add-unit client (sequencer or top level)
// and the multi-cycle adder.
interface fp_add_sub_if #(
  parameter int PRECISION = 32
);
  logic [PRECISION-1:0] A;
  logic [PRECISION-1:0] B;
  logic                 Op;
  logic                 Load;
  logic                 Enable;
  logic [PRECISION-1:0] Result;
  logic                 Valid;

  modport master (output A, B, Op, Load, Enable, input Result, Valid);
  modport slave  (input A, B, Op, Load, Enable, output Result, Valid);
endinterface

// File: rtl/fp_lzc.sv
// Combinational leading-zero counter; an all-zero input reports W.
module fp_lzc #(
  parameter  int W  = 27,
  localparam int CW = $clog2(W + 1)
) (
  input  logic [W-1:0]  data_i,
  output logic [CW-1:0] count_o
);
  always_comb begin
    count_o = CW'(W);
    // Scanning upward lets the highest set bit win.
    for (int i = 0; i < W; i++) begin
      if (data_i[i]) count_o = CW'(W - 1 - i);
    end
  end
endmodule

// File: rtl/fp_add_sub.sv
// Multi-cycle IEEE-754 adder/subtractor: ALIGN, ADD, NORM, ROUND, then holds
// the result with Valid until the next accepted Load. Subnormals are flushed.
module fp_add_sub
  import fp_pkg::*;
#(
  parameter int PRECISION = 32
) (
  input logic         Clk,
  input logic         Reset,
  fp_add_sub_if.slave bus
);
  localparam int E   = exp_msb(PRECISION);
  localparam int M   = man_msb(PRECISION);
  localparam int EW  = E - M;
  localparam int MW  = M + 1;
  localparam int SW  = MW + 4;
  localparam int XW  = EW + 2;
  localparam int LZW = $clog2(SW + 1);
  localparam logic [PRECISION-1:0] NAN_C =
    (PRECISION == 64) ? PRECISION'(DP_NAN) : PRECISION'(SP_NAN);
  localparam logic [EW-1:0]        SW_E    = EW'(SW);
  localparam logic signed [XW-1:0] EXP_MAX = XW'((1 << EW) - 1);

  fp_state_e              state_q, state_d;
  logic [PRECISION-1:0]   a_q, b_q, result_q;
  logic                   valid_q, sign_x_q, sign_y_q, zero_q;
  logic [SW-1:0]          x_sig_q, y_sig_q, sig_q;
  logic signed [XW-1:0]   exp_q;
  logic [SW:0]            sum_q;

  logic                   accept, special;
  logic                   a_nan, b_nan, a_inf, b_inf, a_zero, b_zero;
  logic [PRECISION-1:0]   b_eff, special_res, x_op, y_op, round_res;
  logic                   a_ge, rnd_up;
  logic [EW-1:0]          ediff;
  logic [SW-1:0]          y_full, y_aln, norm_sig;
  logic [SW:0]            sum_d;
  logic [LZW-1:0]         lz;
  logic signed [XW-1:0]   norm_exp, rnd_exp;
  logic [MW+1:0]          rnd_sum;
  logic [MW-1:0]          rnd_man;

  assign accept = bus.Load & bus.Enable;
  assign b_eff  = {bus.B[PRECISION-1] ^ bus.Op, bus.B[PRECISION-2:0]};
  assign a_nan  = (&bus.A[E:MW]) & (|bus.A[M:0]);
  assign b_nan  = (&bus.B[E:MW]) & (|bus.B[M:0]);
  assign a_inf  = (&bus.A[E:MW]) & ~(|bus.A[M:0]);
  assign b_inf  = (&bus.B[E:MW]) & ~(|bus.B[M:0]);
  assign a_zero = ~(|bus.A[E:MW]);
  assign b_zero = ~(|bus.B[E:MW]);

  always_comb begin
    special     = 1'b1;
    special_res = '0;
    if (a_nan | b_nan | (a_inf & b_inf & (bus.A[PRECISION-1] != b_eff[PRECISION-1])))
      special_res = NAN_C;
    else if (a_inf)  special_res = bus.A;
    else if (b_inf)  special_res = b_eff;
    else if (a_zero) special_res = b_eff;
    else if (b_zero) special_res = bus.A;
    else             special = 1'b0;
  end

  always_comb begin
    state_d = state_q;
    if (accept) begin
      state_d = special ? DONE : ALIGN;
    end else if (bus.Enable) begin
      case (state_q)
        ALIGN:   state_d = ADD;
        ADD:     state_d = NORM;
        NORM:    state_d = ROUND;
        ROUND:   state_d = DONE;
        default: state_d = state_q;
      endcase
    end
  end

  // Alignment: larger magnitude becomes X; Y is shifted with a sticky LSB.
  always_comb begin
    a_ge   = a_q[E:0] >= b_q[E:0];
    x_op   = a_ge ? a_q : b_q;
    y_op   = a_ge ? b_q : a_q;
    ediff  = x_op[E:MW] - y_op[E:MW];
    y_full = {1'b1, y_op[M:0], 3'b000};
    if (ediff >= SW_E) y_aln = SW'(1);
    else y_aln = (y_full >> ediff) | SW'(|(y_full & ~({SW{1'b1}} << ediff)));
  end

  assign sum_d = (sign_x_q == sign_y_q) ? ({1'b0, x_sig_q} + {1'b0, y_sig_q})
                                        : ({1'b0, x_sig_q} - {1'b0, y_sig_q});

  fp_lzc #(.W(SW)) u_lzc (
    .data_i  (sum_q[SW-1:0]),
    .count_o (lz)
  );

  always_comb begin
    if (sum_q[SW]) begin
      norm_sig = {sum_q[SW:2], sum_q[1] | sum_q[0]};
      norm_exp = exp_q + XW'(1);
    end else begin
      norm_sig = sum_q[SW-1:0] << lz;
      norm_exp = exp_q - XW'(lz);
    end
  end

  // Round to nearest even on {G,R,S}; overflow of the significand bumps the exponent.
  always_comb begin
    rnd_up  = sig_q[2] & (sig_q[1] | sig_q[0] | sig_q[3]);
    rnd_sum = {1'b0, sig_q[SW-1:3]} + (MW+2)'(rnd_up);
    rnd_exp = exp_q + XW'(rnd_sum[MW+1]);
    rnd_man = rnd_sum[MW+1] ? rnd_sum[MW:1] : rnd_sum[MW-1:0];
    if (zero_q || rnd_exp[XW-1] || (rnd_exp == '0))
      round_res = '0;
    else if (rnd_exp >= EXP_MAX)
      round_res = {sign_x_q, {EW{1'b1}}, {MW{1'b0}}};
    else
      round_res = {sign_x_q, rnd_exp[EW-1:0], rnd_man};
  end

  always_ff @(posedge Clk or posedge Reset) begin
    if (Reset)           state_q <= IDLE;
    else if (bus.Enable) state_q <= state_d;
  end

  always_ff @(posedge Clk or posedge Reset) begin
    if (Reset) begin
      a_q <= '0; b_q <= '0; result_q <= '0; valid_q <= 1'b0;
      x_sig_q <= '0; y_sig_q <= '0; sig_q <= '0; sum_q <= '0;
      sign_x_q <= 1'b0; sign_y_q <= 1'b0; zero_q <= 1'b0; exp_q <= '0;
    end else if (bus.Enable) begin
      if (bus.Load) begin
        a_q     <= bus.A;
        b_q     <= b_eff;
        valid_q <= 1'b0;
        if (special) result_q <= special_res;
      end else begin
        case (state_q)
          ALIGN: begin
            x_sig_q  <= {1'b1, x_op[M:0], 3'b000};
            y_sig_q  <= y_aln;
            sign_x_q <= x_op[PRECISION-1];
            sign_y_q <= y_op[PRECISION-1];
            exp_q    <= XW'(x_op[E:MW]);
          end
          ADD:  sum_q <= sum_d;
          NORM: begin
            sig_q  <= norm_sig;
            exp_q  <= norm_exp;
            zero_q <= (sum_q == '0);
          end
          ROUND: begin
            result_q <= round_res;
            valid_q  <= 1'b1;
          end
          DONE:    valid_q <= 1'b1;
          default: ;
        endcase
      end
    end
  end

  assign bus.Result = result_q;
  assign bus.Valid  = valid_q;
endmodule

// File: tb/tb_fp_add_sub.sv
// Bench for the single-precision adder: directed cases, control scenarios and
// random operands against a real-arithmetic reference.
module tb_fp_add_sub;
  logic clk = 1'b0;
  logic rst;
  int   errors = 0;
  int   checks = 0;

  always #5 clk = ~clk;

  fp_add_sub_if #(.PRECISION(32)) bus ();
  fp_add_sub #(.PRECISION(32)) dut (.Clk(clk), .Reset(rst), .bus(bus));

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  function automatic real f2r(input logic [31:0] x);
    real r;
    r = (1.0 + real'(x[22:0]) / 8388608.0) * (2.0 ** real'(int'(x[30:23]) - 127));
    return x[31] ? -r : r;
  endfunction

  // Round a double to single, ties to even, flushing results below the normal range to +0.
  function automatic logic [31:0] r2f(input real r);
    logic [63:0] bits;
    logic [52:0] m;
    logic [24:0] kept;
    logic [22:0] mant;
    logic        up;
    int          fe;
    bits = $realtobits(r);
    if (bits[62:52] == 11'd0) return 32'h0;
    fe   = int'(bits[62:52]) - 1023 + 127;
    m    = {1'b1, bits[51:0]};
    up   = (m[28:0] > 29'h1000_0000) || ((m[28:0] == 29'h1000_0000) && m[29]);
    kept = {1'b0, m[52:29]} + 25'(up);
    if (kept[24]) begin fe++; mant = kept[23:1]; end
    else mant = kept[22:0];
    if (fe >= 255) return {bits[63], 8'hFF, 23'h0};
    if (fe <= 0) return 32'h0;
    return {bits[63], fe[7:0], mant};
  endfunction

  // Returns {special_path, result}.
  function automatic logic [32:0] ref_add(input logic [31:0] a, input logic [31:0] b, input logic op);
    logic [31:0] be;
    logic a_nan, b_nan, a_inf, b_inf;
    be    = {b[31] ^ op, b[30:0]};
    a_nan = (a[30:23] == 8'hFF) && (a[22:0] != 0);
    b_nan = (b[30:23] == 8'hFF) && (b[22:0] != 0);
    a_inf = (a[30:23] == 8'hFF) && (a[22:0] == 0);
    b_inf = (b[30:23] == 8'hFF) && (b[22:0] == 0);
    if (a_nan || b_nan || (a_inf && b_inf && a[31] != be[31])) return {1'b1, 32'h7FFF_FFFF};
    if (a_inf) return {1'b1, a};
    if (b_inf) return {1'b1, be};
    if (a[30:23] == 0) return {1'b1, be};
    if (b[30:23] == 0) return {1'b1, a};
    return {1'b0, r2f(f2r(a) + f2r(be))};
  endfunction

  task automatic start(input logic [31:0] a, input logic [31:0] b, input logic op);
    @(posedge clk); #1;
    bus.A = a; bus.B = b; bus.Op = op; bus.Load = 1'b1;
    @(posedge clk); #1;
    bus.Load = 1'b0;
  endtask

  task automatic wait_valid(output int n);
    n = 0;
    while (bus.Valid !== 1'b1 && n < 40) begin
      @(posedge clk); #1;
      n++;
    end
  endtask

  task automatic run(input string tag, input logic [31:0] a, input logic [31:0] b,
                     input logic op, input logic [31:0] exp_res, input int exp_lat);
    int n;
    start(a, b, op);
    check({tag, "/valid_low"}, 64'(bus.Valid), 64'd0);
    wait_valid(n);
    check({tag, "/latency"}, 64'(n), 64'(exp_lat));
    check({tag, "/result"}, 64'(bus.Result), 64'(exp_res));
    $display("%s: %h %s %h -> %h (want %h) latency %0d", tag, a, op ? "-" : "+", b,
             bus.Result, exp_res, n);
  endtask

  initial begin
    int n, seen, bad;
    logic [31:0] a, b;
    logic [32:0] r;
    logic        op;
    rst = 1'b1; bus.Load = 1'b0; bus.Enable = 1'b1;
    bus.A = '0; bus.B = '0; bus.Op = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    check("reset/valid", 64'(bus.Valid), 64'd0);
    check("reset/result", 64'(bus.Result), 64'd0);
    rst = 1'b0;

    run("add_1_2",   32'h3F800000, 32'h40000000, 1'b0, 32'h40400000, 4);
    run("sub_2_1",   32'h40000000, 32'h3F800000, 1'b1, 32'h3F800000, 4);
    run("sub_1_1",   32'h3F800000, 32'h3F800000, 1'b1, 32'h00000000, 4);
    run("tie_even",  32'h3F800000, 32'h33800000, 1'b0, 32'h3F800000, 4);
    run("round_up",  32'h3F800000, 32'h33C00000, 1'b0, 32'h3F800001, 4);
    run("ovf_inf",   32'h7F7FFFFF, 32'h7F7FFFFF, 1'b0, 32'h7F800000, 4);
    run("inf_m_inf", 32'h7F800000, 32'h7F800000, 1'b1, 32'h7FFFFFFF, 1);
    run("nan_in",    32'h7FC00000, 32'h3F800000, 1'b0, 32'h7FFFFFFF, 1);
    run("subnorm",   32'h00000001, 32'h3F800000, 1'b0, 32'h3F800000, 1);
    run("div_48_32", 32'h4034B4B5, 32'h3FF0F0F1, 1'b1, 32'h3F70F0F2, 4);

    // Abort: second Load lands while the first operation is in ALIGN.
    @(posedge clk); #1;
    bus.A = 32'h3F800000; bus.B = 32'h3F800000; bus.Op = 1'b0; bus.Load = 1'b1;
    @(posedge clk); #1;
    bus.A = 32'h40400000;
    @(posedge clk); #1;
    bus.Load = 1'b0;
    seen = 0; bad = 0;
    for (int i = 0; i < 12; i++) begin
      if (bus.Valid === 1'b1) begin
        seen++;
        if (bus.Result !== 32'h40800000) bad++;
      end
      @(posedge clk); #1;
    end
    check("abort/bad_results", 64'(bad), 64'd0);
    check("abort/valid_cycles", 64'(seen), 64'd8);
    $display("abort: valid cycles %0d, wrong results %0d, result %h", seen, bad, bus.Result);

    // Reset while the operation sits in ROUND.
    start(32'h3F800000, 32'h40000000, 1'b0);
    repeat (3) @(posedge clk);
    #1;
    rst = 1'b1;
    #1;
    check("rst_mid/valid", 64'(bus.Valid), 64'd0);
    check("rst_mid/result", 64'(bus.Result), 64'd0);
    @(posedge clk); #1;
    rst = 1'b0;
    seen = 0;
    for (int i = 0; i < 8; i++) begin
      @(posedge clk); #1;
      if (bus.Valid === 1'b1) seen++;
    end
    check("rst_mid/no_completion", 64'(seen), 64'd0);
    $display("reset_mid_round: result %h, late valid cycles %0d", bus.Result, seen);

    // Enable low for three cycles stretches latency by three.
    start(32'h3F800000, 32'h40000000, 1'b0);
    bus.Enable = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    bus.Enable = 1'b1;
    wait_valid(n);
    check("enable/latency", 64'(n + 3), 64'd7);
    check("enable/result", 64'(bus.Result), 64'h40400000);
    $display("enable_stall: result %h latency %0d", bus.Result, n + 3);

    for (int t = 0; t < 150; t++) begin
      int ea, eb;
      a  = $urandom;
      b  = $urandom;
      op = 1'($urandom_range(0, 1));
      if ($urandom_range(0, 3) != 0) begin
        ea = int'($urandom_range(1, 254));
        eb = ea + int'($urandom_range(0, 60)) - 30;
        if (eb < 1) eb = 1;
        if (eb > 254) eb = 254;
        a[30:23] = ea[7:0];
        b[30:23] = eb[7:0];
        if ($urandom_range(0, 7) == 0) b[22:0] = a[22:0];
      end
      r = ref_add(a, b, op);
      run("rnd", a, b, op, r[31:0], r[32] ? 1 : 4);
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
